// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags, programmable almost flags,
// overflow/underflow pulses with sticky copies, and an optional FWFT read port.
module sync_fifo #(
  parameter int DATA_LENGTH     = 32,
  parameter int MEMORY_SIZE     = 32,
  parameter int ADDRESS_WIDTH   = $clog2(MEMORY_SIZE),
  parameter int FWFT            = 0,
  parameter int ALMOST_FULL_TH  = MEMORY_SIZE - 2,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                     clk,
  input  logic                     rst_fifo,
  input  logic                     wr_en,
  input  logic [DATA_LENGTH-1:0]   data_in,
  input  logic                     rd_en,
  input  logic                     err_clr,
  output logic [DATA_LENGTH-1:0]   data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [ADDRESS_WIDTH:0]   count,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     overflow_sticky,
  output logic                     underflow_sticky
);

  localparam int CW = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = CW'(MEMORY_SIZE);
  localparam logic [CW-1:0] AF_TH = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0] AE_TH = CW'(ALMOST_EMPTY_TH);

  logic [DATA_LENGTH-1:0] ram [MEMORY_SIZE];

  logic [CW-1:0] wr_ptr_reg, rd_ptr_reg, count_reg, count_next;
  logic          full_reg, empty_reg, almost_full_reg, almost_empty_reg;
  logic          overflow_reg, underflow_reg, overflow_sticky_reg, underflow_sticky_reg;
  logic          wr_ok, rd_ok;

  // Acceptance is judged on the registered flags, i.e. the state before the edge.
  assign wr_ok = wr_en & ~full_reg;
  assign rd_ok = rd_en & ~empty_reg;

  always_comb begin
    count_next = count_reg;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // RAM has no reset; writes are suppressed while the FIFO is held in reset.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst_fifo) begin
      ram[wr_ptr_reg[ADDRESS_WIDTH-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst_fifo) begin
    if (rst_fifo) begin
      wr_ptr_reg           <= '0;
      rd_ptr_reg           <= '0;
      count_reg            <= '0;
      full_reg             <= 1'b0;
      empty_reg            <= 1'b1;
      almost_full_reg      <= 1'b0;
      almost_empty_reg     <= 1'b1;
      overflow_reg         <= 1'b0;
      underflow_reg        <= 1'b0;
      overflow_sticky_reg  <= 1'b0;
      underflow_sticky_reg <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + CW'(1);
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + CW'(1);
      count_reg            <= count_next;
      full_reg             <= (count_next == DEPTH);
      empty_reg            <= (count_next == '0);
      almost_full_reg      <= (count_next >= AF_TH);
      almost_empty_reg     <= (count_next <= AE_TH);
      overflow_reg         <= wr_en & full_reg;
      underflow_reg        <= rd_en & empty_reg;
      // A new error on the clearing edge keeps the flag set.
      overflow_sticky_reg  <= (overflow_sticky_reg & ~err_clr) | (wr_en & full_reg);
      underflow_sticky_reg <= (underflow_sticky_reg & ~err_clr) | (rd_en & empty_reg);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = ram[rd_ptr_reg[ADDRESS_WIDTH-1:0]];
    end else begin : g_std
      logic [DATA_LENGTH-1:0] data_out_reg;
      always_ff @(posedge clk or posedge rst_fifo) begin
        if (rst_fifo) begin
          data_out_reg <= '0;
        end else if (rd_ok) begin
          data_out_reg <= ram[rd_ptr_reg[ADDRESS_WIDTH-1:0]];
        end
      end
      assign data_out = data_out_reg;
    end
  endgenerate

  assign full             = full_reg;
  assign empty            = empty_reg;
  assign almost_full      = almost_full_reg;
  assign almost_empty     = almost_empty_reg;
  assign count            = count_reg;
  assign overflow         = overflow_reg;
  assign underflow        = underflow_reg;
  assign overflow_sticky  = overflow_sticky_reg;
  assign underflow_sticky = underflow_sticky_reg;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a standard-mode and an FWFT instance share
// stimulus and are compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_sync_fifo;
  localparam int DW = 32;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_fifo = 1'b0;
  logic wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] s_dout, f_dout;
  logic s_full, s_empty, s_af, s_ae, s_ovf, s_unf, s_os, s_us;
  logic f_full, f_empty, f_af, f_ae, f_ovf, f_unf, f_os, f_us;
  logic [5:0] s_count, f_count;

  sync_fifo #(.DATA_LENGTH(DW), .MEMORY_SIZE(DEPTH), .FWFT(0)) dut_std (
    .clk(clk), .rst_fifo(rst_fifo), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .err_clr(err_clr), .data_out(s_dout), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count), .overflow(s_ovf),
    .underflow(s_unf), .overflow_sticky(s_os), .underflow_sticky(s_us));

  sync_fifo #(.DATA_LENGTH(DW), .MEMORY_SIZE(DEPTH), .FWFT(1)) dut_fw (
    .clk(clk), .rst_fifo(rst_fifo), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .err_clr(err_clr), .data_out(f_dout), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .overflow(f_ovf),
    .underflow(f_unf), .overflow_sticky(f_os), .underflow_sticky(f_us));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: contents as a queue, plus expected error state.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  bit m_ovf = 0, m_unf = 0, m_os = 0, m_us = 0;

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf = 0; m_unf = 0; m_os = 0; m_us = 0;
  endtask

  // One clock: drive requests, advance the model, return at posedge+1.
  task automatic cycle(input bit wr, input logic [DW-1:0] din, input bit rd, input bit clr);
    bit wr_ok, rd_ok;
    wr_en = wr; data_in = din; rd_en = rd; err_clr = clr;
    wr_ok = wr && (q.size() < DEPTH);
    rd_ok = rd && (q.size() > 0);
    @(posedge clk); #1;
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(din);
    m_ovf = wr && !wr_ok;
    m_unf = rd && !rd_ok;
    m_os = (m_os && !clr) || m_ovf;
    m_us = (m_us && !clr) || m_unf;
    wr_en = 0; rd_en = 0; err_clr = 0;
  endtask

  task automatic test_reset();
    #2 rst_fifo = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (s_count !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", s_count); end
    n_checks++; if ({s_empty, s_ae, s_full, s_af} !== 4'b1100) begin n_fail++; $display("FAIL reset_flags: got e/ae/f/af=%b expected 1100", {s_empty, s_ae, s_full, s_af}); end
    n_checks++; if ({s_ovf, s_unf, s_os, s_us} !== 4'b0000) begin n_fail++; $display("FAIL reset_err: got %b expected 0000", {s_ovf, s_unf, s_os, s_us}); end
    n_checks++; if (s_dout !== 32'd0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", s_dout); end
    rst_fifo = 1'b0;
    model_reset();
    $display("reset: released");
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 32'(i), 0, 0);
      n_checks++; if (s_count !== 6'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, s_count, i + 1); end
      n_checks++; if (s_af !== ((i + 1) >= 30)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b expected %b", i, s_af, (i + 1) >= 30); end
      n_checks++; if (s_full !== ((i + 1) == 32)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b expected %b", i, s_full, (i + 1) == 32); end
      n_checks++; if ({s_empty, s_ae} !== {1'b0, (i + 1) <= 2}) begin n_fail++; $display("FAIL fill_empty[%0d]: got e/ae=%b%b", i, s_empty, s_ae); end
      $display("fill: write %0d count=%0d af=%b full=%b", i, s_count, s_af, s_full);
    end
    cycle(1, 32'hDEAD_0033, 0, 0);
    n_checks++; if ({s_ovf, s_os, s_count} !== {1'b1, 1'b1, 6'd32}) begin n_fail++; $display("FAIL fill_overflow: got ovf=%b os=%b count=%0d expected 1 1 32", s_ovf, s_os, s_count); end
    cycle(0, 0, 0, 0);
    n_checks++; if ({s_ovf, s_os} !== 2'b01) begin n_fail++; $display("FAIL fill_ovf_pulse: got ovf=%b os=%b expected 0 1", s_ovf, s_os); end
    cycle(0, 0, 0, 1);
    n_checks++; if (s_os !== 1'b0) begin n_fail++; $display("FAIL fill_errclr: got os=%b expected 0", s_os); end
    $display("fill: overflow pulse and clear done");
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (f_dout !== 32'(i)) begin n_fail++; $display("FAIL drain_fwft[%0d]: got %h expected %h", i, f_dout, i); end
      cycle(0, 0, 1, 0);
      n_checks++; if (s_dout !== 32'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h expected %h", i, s_dout, i); end
      $display("drain: read %0d data=%h count=%0d", i, s_dout, s_count);
    end
    n_checks++; if ({s_empty, s_count} !== {1'b1, 6'd0}) begin n_fail++; $display("FAIL drain_empty: got empty=%b count=%0d expected 1 0", s_empty, s_count); end
    cycle(0, 0, 1, 0);
    n_checks++; if ({s_unf, s_us} !== 2'b11) begin n_fail++; $display("FAIL drain_underflow: got unf=%b us=%b expected 1 1", s_unf, s_us); end
    n_checks++; if (s_dout !== 32'd31) begin n_fail++; $display("FAIL drain_hold: got %h expected 1f", s_dout); end
    cycle(0, 0, 0, 0);
    n_checks++; if ({s_unf, s_us} !== 2'b01) begin n_fail++; $display("FAIL drain_unf_pulse: got unf=%b us=%b expected 0 1", s_unf, s_us); end
  endtask

  task automatic test_fwft();
    cycle(1, 32'hA5A5_A5A5, 0, 0);
    n_checks++; if (f_dout !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL fwft_data: got %h expected a5a5a5a5", f_dout); end
    n_checks++; if ({f_empty, f_count} !== {1'b0, 6'd1}) begin n_fail++; $display("FAIL fwft_flags: got empty=%b count=%0d expected 0 1", f_empty, f_count); end
    cycle(0, 0, 1, 0);
    n_checks++; if ({f_empty, f_count} !== {1'b1, 6'd0}) begin n_fail++; $display("FAIL fwft_read: got empty=%b count=%0d expected 1 0", f_empty, f_count); end
    n_checks++; if (s_dout !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL fwft_std_data: got %h expected a5a5a5a5", s_dout); end
    $display("fwft: word a5a5a5a5 passed through");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) cycle(1, $urandom, 0, 0);
    for (int i = 0; i < 100; i++) begin
      cycle(1, $urandom, 1, 0);
      n_checks++; if (s_count !== 6'd5) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected 5", i, s_count); end
      n_checks++; if (s_dout !== m_dout) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, s_dout, m_dout); end
      n_checks++; if (f_dout !== q[0]) begin n_fail++; $display("FAIL b2b_fwft[%0d]: got %h expected %h", i, f_dout, q[0]); end
      n_checks++; if ({s_ovf, s_unf} !== 2'b00) begin n_fail++; $display("FAIL b2b_err[%0d]: got ovf=%b unf=%b", i, s_ovf, s_unf); end
      $display("b2b: cycle %0d data=%h count=%0d", i, s_dout, s_count);
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] w;
    while (q.size() < DEPTH) cycle(1, $urandom, 0, 0);
    cycle(1, $urandom, 1, 0);
    n_checks++; if ({s_count, s_ovf} !== {6'd31, 1'b1}) begin n_fail++; $display("FAIL simul_full: got count=%0d ovf=%b expected 31 1", s_count, s_ovf); end
    n_checks++; if (s_dout !== m_dout) begin n_fail++; $display("FAIL simul_full_data: got %h expected %h", s_dout, m_dout); end
    while (q.size() > 0) cycle(0, 0, 1, 0);
    w = $urandom;
    cycle(1, w, 1, 0);
    n_checks++; if ({s_count, s_unf} !== {6'd1, 1'b1}) begin n_fail++; $display("FAIL simul_empty: got count=%0d unf=%b expected 1 1", s_count, s_unf); end
    n_checks++; if (f_dout !== w) begin n_fail++; $display("FAIL simul_empty_data: got %h expected %h", f_dout, w); end
    cycle(0, 0, 1, 1);
    $display("simul: full and empty corner cases done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = (i < 200) ? 70 : 30;
      cycle($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < (100 - wp),
            $urandom_range(0, 99) < 5);
      n_checks++;
      if ({s_count, s_full, s_empty, s_af, s_ae} !==
          {6'(q.size()), q.size() == DEPTH, q.size() == 0, q.size() >= DEPTH - 2, q.size() <= 2}) begin
        n_fail++; $display("FAIL rand_status[%0d]: got count=%0d f/e/af/ae=%b%b%b%b expected count=%0d", i, s_count, s_full, s_empty, s_af, s_ae, q.size());
      end
      n_checks++;
      if ({s_ovf, s_unf, s_os, s_us} !== {m_ovf, m_unf, m_os, m_us}) begin
        n_fail++; $display("FAIL rand_err[%0d]: got %b expected %b", i, {s_ovf, s_unf, s_os, s_us}, {m_ovf, m_unf, m_os, m_us});
      end
      n_checks++; if (s_dout !== m_dout) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", i, s_dout, m_dout); end
      if (q.size() > 0) begin
        n_checks++; if (f_dout !== q[0]) begin n_fail++; $display("FAIL rand_fwft[%0d]: got %h expected %h", i, f_dout, q[0]); end
      end
      $display("rand: cycle %0d count=%0d data=%h", i, s_count, s_dout);
    end
  endtask

  task automatic test_reset_mid();
    #2 rst_fifo = 1'b1;
    #2 rst_fifo = 1'b0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, 32'hC000_0000 | 32'(i), 0, 0);
    cycle(1, 32'h0, 0, 0);
    for (int i = 0; i < 15; i++) cycle(0, 0, 1, 0);
    n_checks++; if ({s_count, s_os} !== {6'd17, 1'b1}) begin n_fail++; $display("FAIL midrst_pre: got count=%0d os=%b expected 17 1", s_count, s_os); end
    #2 rst_fifo = 1'b1;
    #1;
    n_checks++; if (s_count !== 6'd0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", s_count); end
    n_checks++; if ({s_empty, s_ae, s_full, s_af} !== 4'b1100) begin n_fail++; $display("FAIL midrst_flags: got %b expected 1100", {s_empty, s_ae, s_full, s_af}); end
    n_checks++; if ({s_ovf, s_unf, s_os, s_us, s_dout} !== 36'd0) begin n_fail++; $display("FAIL midrst_err_dout: got %b %h expected 0", {s_ovf, s_unf, s_os, s_us}, s_dout); end
    wr_en = 1'b1; data_in = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    n_checks++; if (s_count !== 6'd0) begin n_fail++; $display("FAIL midrst_ignore: got count=%0d expected 0", s_count); end
    wr_en = 1'b0;
    rst_fifo = 1'b0;
    model_reset();
    cycle(1, 32'h1234_5678, 0, 0);
    n_checks++; if ({f_count, f_dout} !== {6'd1, 32'h1234_5678}) begin n_fail++; $display("FAIL midrst_fwft: got count=%0d data=%h expected 1 12345678", f_count, f_dout); end
    cycle(0, 0, 1, 0);
    n_checks++; if (s_dout !== 32'h1234_5678) begin n_fail++; $display("FAIL midrst_data: got %h expected 12345678", s_dout); end
    $display("midrst: new data %h read after reset", s_dout);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_fwft();
    test_back_to_back();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised successor to the dual-clock sample FIFO, used where producer and consumer share one clock, e.g. the buffer between sample capture and the FIR tap pipeline. Stores DATA_LENGTH-bit words in a power-of-two RAM and provides:
- registered full/empty, programmable almost-full/almost-empty and an occupancy count;
- registered overflow/underflow pulses plus sticky error flags;
- a selectable first-word-fall-through (FWFT) read mode.

## Interface
- DATA_LENGTH, 32, word width in bits
- MEMORY_SIZE, 32, depth in words; must be a power of two, at least 4
- ADDRESS_WIDTH, $clog2(MEMORY_SIZE), RAM address width; pointers and count are ADDRESS_WIDTH+1 bits
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through
- ALMOST_FULL_TH, MEMORY_SIZE-2, almost_full asserts when count >= this value
- ALMOST_EMPTY_TH, 2, almost_empty asserts when count <= this value

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_fifo  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- data_in  in  DATA_LENGTH  write data
- rd_en  in  1  read request / acknowledge
- err_clr  in  1  clears the sticky error flags
- data_out  out  DATA_LENGTH  read data
- full  out  1  count == MEMORY_SIZE
- empty  out  1  count == 0
- almost_full  out  1  count >= ALMOST_FULL_TH
- almost_empty  out  1  count <= ALMOST_EMPTY_TH
- count  out  ADDRESS_WIDTH+1  words stored, range 0..MEMORY_SIZE
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected
- overflow_sticky  out  1  latched overflow
- underflow_sticky  out  1  latched underflow

## Operation
- Acceptance rules:
  - A write is accepted when wr_en=1 and full=0.
  - A read is accepted when rd_en=1 and empty=0.
  - Each rule uses the flag value before the edge. There is no write-through-on-full and no read-through-on-empty.
- Write: RAM[wr_ptr[ADDRESS_WIDTH-1:0]] <= data_in, then wr_ptr increments.
- Read: rd_ptr increments.
- Pointers are ADDRESS_WIDTH+1 bits and wrap naturally (modulo 2*MEMORY_SIZE). The low ADDRESS_WIDTH bits address the RAM.
- count update on each edge: +1 for an accepted write only, -1 for an accepted read only, unchanged when both or neither are accepted.
- All flags are registered and derived from the next-state count, so they change on the same edge as count.
- FWFT=0 (standard mode):
  - On an accepted read, data_out <= RAM[rd_ptr] at that edge.
  - data_out holds its value otherwise, including on a rejected read.
- FWFT=1:
  - data_out = RAM[rd_ptr[ADDRESS_WIDTH-1:0]] continuously.
  - data_out is valid whenever empty=0; an accepted read acknowledges it and advances to the next word.
  - data_out is don't-care while empty=1.
- Rejected requests:
  - A rejected write asserts overflow for exactly the next cycle and sets overflow_sticky.
  - A rejected read does the same for underflow and underflow_sticky.
  - RAM, pointers and count are unaffected.
- Sticky flags:
  - err_clr=1 clears both sticky flags at the edge.
  - If a new error occurs on the same edge as err_clr, the sticky flag ends up set (set wins).
- Simultaneous requests:
  - Full with wr_en and rd_en: the read is accepted, the write is rejected (overflow pulses), and count becomes MEMORY_SIZE-1.
  - Empty with wr_en and rd_en: the write is accepted, the read is rejected (underflow pulses), and count becomes 1.
- Reset:
  - Asserting rst_fifo mid-operation immediately clears pointers, count, data_out, overflow, underflow and both sticky flags.
  - Reset values: empty=1, almost_empty=1 (since ALMOST_EMPTY_TH >= 0), full=0, almost_full=0.
  - RAM contents are not cleared.
- Requests are ignored while rst_fifo=1. The first accepted request is on the first rising edge after deassertion.

## Timing
- Write to flag update: empty falls, count increments and almost flags update at the same edge that stores the word.
- Write to read visibility:
  - FWFT=1: the word is on data_out during the cycle after the write edge.
  - FWFT=0: the word can be read with rd_en in the cycle after the write edge; data_out shows it one edge later.
- Read latency: FWFT=0 gives 1 cycle from the rd_en edge to data_out; FWFT=1 gives 0 cycles (data is already present).
- Throughput: one write and one read per cycle, sustained, with no bubbles at pointer wrap-around.
- overflow/underflow: high for the single cycle after the offending edge, low otherwise.

## Test plan
- Reset then fill: 32 consecutive writes of 0..31 (MEMORY_SIZE=32).
  - almost_full rises after write 30 (count=30).
  - full rises after write 32 (count=32).
  - A 33rd write pulses overflow for one cycle, and overflow_sticky stays 1 until err_clr.
- Drain in FWFT=0: 32 reads return 0..31, each one cycle after its rd_en edge.
  - empty=1 after read 32.
  - An extra read pulses underflow, and data_out holds 31.
- FWFT=1: write 0xA5A5A5A5 into an empty FIFO.
  - data_out shows 0xA5A5A5A5 the next cycle with empty=0.
  - rd_en returns empty=1 and count=0.
- Simultaneous requests:
  - Write and read every cycle for 100 cycles from count=5: count stays 5, data is in order, and the pointers wrap cleanly.
  - When full, both requests give count=31 and overflow=1.
  - When empty, both requests give count=1 and underflow=1.
- Reset mid-operation with count=17 and overflow_sticky=1: all outputs return to their reset values without waiting for a clock edge.
  - A subsequent write then read returns the new data, not stale RAM contents.
